// File: rtl/pic_pkg.sv
// Shared encodings for the pic_core_n interrupt controller: register map,
// mode/command bit positions and the acknowledge FSM state type.
package pic_pkg;

    localparam logic [1:0] ADDR_IMR   = 2'd0;
    localparam logic [1:0] ADDR_VBASE = 2'd1;
    localparam logic [1:0] ADDR_MODE  = 2'd2;
    localparam logic [1:0] ADDR_CMD   = 2'd3;

    localparam logic [1:0] RD_IRR    = 2'd0;
    localparam logic [1:0] RD_ISR    = 2'd1;
    localparam logic [1:0] RD_IMR    = 2'd2;
    localparam logic [1:0] RD_STATUS = 2'd3;

    localparam int MODE_LEVEL    = 0;
    localparam int MODE_AEOI     = 1;
    localparam int MODE_ROT_AEOI = 2;

    localparam logic [1:0] CMD_NSEOI = 2'd1;
    localparam logic [1:0] CMD_SEOI  = 2'd2;
    localparam int         CMD_ROT_BIT = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK1 = 2'd2
    } state_e;

    // Distance of idx from the rotating base: 0 is the highest priority.
    function automatic int ring_dist(input int idx, input int base, input int n);
        return (idx + n - base) % n;
    endfunction

endpackage

// File: rtl/pic_prio_rotate.sv
// Rotating first-set finder: the bit at base_i has the highest priority,
// then base_i+1, wrapping modulo N_IRQ.
module pic_prio_rotate #(
    parameter  int N_IRQ = 8,
    localparam int IDX_W = $clog2(N_IRQ)
) (
    input  logic [N_IRQ-1:0] req_i,
    input  logic [IDX_W-1:0] base_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [N_IRQ-1:0] rot;
    logic [IDX_W-1:0] pos;

    always_comb begin
        rot     = (req_i >> base_i) | (req_i << (N_IRQ - int'(base_i)));
        found_o = |rot;
        pos     = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (rot[k]) pos = IDX_W'(k);
        end
        idx_o = IDX_W'((int'(pos) + int'(base_i)) % N_IRQ);
    end

endmodule

// File: rtl/pic_core_n.sv
// Single-chip 8259-style interrupt core: request capture, fully nested
// rotating priority, EOI/AEOI handling and the two-pulse INTA_ handshake.
module pic_core_n
    import pic_pkg::*;
#(
    parameter  int N_IRQ = 8,
    parameter  int VEC_W = 8,
    localparam int IDX_W = $clog2(N_IRQ),
    localparam int DW    = (N_IRQ > VEC_W) ? N_IRQ : VEC_W
) (
    input  logic             CLK,
    input  logic             RST_,
    input  logic [N_IRQ-1:0] IRQ,
    input  logic             WR,
    input  logic [1:0]       ADDR,
    input  logic [DW-1:0]    WDATA,
    input  logic [1:0]       RD_SEL,
    output logic [DW-1:0]    RDATA,
    output logic             INT,
    input  logic             INTA_,
    output logic [VEC_W-1:0] VEC,
    output logic             VEC_VALID
);

    localparam int WX = (DW > 8) ? DW : 8;
    localparam logic [VEC_W-1:0] IDX_MASK = VEC_W'((1 << IDX_W) - 1);

    logic [WX-1:0]    wd;
    logic [N_IRQ-1:0] irq_q, irr_q, irr_d, isr_q, isr_d, imr_q;
    logic [N_IRQ-1:0] isr_set, eoi_clr, aeoi_clr;
    logic [VEC_W-1:0] vbase_q, vec_q;
    logic [2:0]       mode_q;
    logic [IDX_W-1:0] base_q, base_d, idx_q, eoi_idx, sidx;
    logic [IDX_W-1:0] cand_idx, isr_idx;
    logic             cand_found, isr_found, cand_ok;
    logic             inta_q, inta_fall, ack_take, ack_fin, cmd_wr;
    logic             int_q, spur_q, vec_valid_q;
    state_e           state_q;

    function automatic logic [N_IRQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return {{(N_IRQ-1){1'b0}}, 1'b1} << i;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(N_IRQ - 1)) ? '0 : i + 1'b1;
    endfunction

    assign wd = WX'(WDATA);
    assign sidx = wd[IDX_W+1:2];

    pic_prio_rotate #(.N_IRQ(N_IRQ)) u_cand (
        .req_i(irr_q & ~imr_q), .base_i(base_q), .found_o(cand_found), .idx_o(cand_idx)
    );
    pic_prio_rotate #(.N_IRQ(N_IRQ)) u_isr (
        .req_i(isr_q), .base_i(base_q), .found_o(isr_found), .idx_o(isr_idx)
    );

    // Fully nested: a request must beat every line already in service.
    assign cand_ok = cand_found && (!isr_found ||
        ring_dist(int'(cand_idx), int'(base_q), N_IRQ) < ring_dist(int'(isr_idx), int'(base_q), N_IRQ));

    assign inta_fall = inta_q & ~INTA_;
    assign ack_take  = (state_q == PEND) && inta_fall && cand_ok;
    assign ack_fin   = (state_q == ACK1) && inta_fall;
    assign cmd_wr    = WR && (ADDR == ADDR_CMD);

    always_comb begin
        irr_d = mode_q[MODE_LEVEL] ? ((irr_q & isr_q) | (IRQ & ~isr_q))
                                   : (irr_q | (IRQ & ~irq_q));
        isr_set = ack_take ? onehot(cand_idx) : '0;
        irr_d   = irr_d & ~isr_set;
        eoi_clr = '0;
        eoi_idx = '0;
        if (cmd_wr) begin
            if (wd[1:0] == CMD_NSEOI && isr_found) begin
                eoi_clr = onehot(isr_idx);
                eoi_idx = isr_idx;
            end else if (wd[1:0] == CMD_SEOI) begin
                eoi_clr = onehot(sidx) & (isr_q | isr_set);
                eoi_idx = sidx;
            end
        end
        aeoi_clr = (ack_fin && mode_q[MODE_AEOI] && !spur_q) ? onehot(idx_q) : '0;
        isr_d    = (isr_q | isr_set) & ~(eoi_clr | aeoi_clr);
        base_d   = base_q;
        if (|eoi_clr && wd[CMD_ROT_BIT]) base_d = next_ptr(eoi_idx);
        if (|aeoi_clr && mode_q[MODE_ROT_AEOI]) base_d = next_ptr(idx_q);
    end

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            irq_q       <= '0;
            inta_q      <= 1'b1;
            irr_q       <= '0;
            isr_q       <= '0;
            imr_q       <= '1;
            vbase_q     <= '0;
            mode_q      <= '0;
            base_q      <= '0;
            idx_q       <= '0;
            spur_q      <= 1'b0;
            int_q       <= 1'b0;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
            state_q     <= IDLE;
        end else begin
            irq_q       <= IRQ;
            inta_q      <= INTA_;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            base_q      <= base_d;
            vec_valid_q <= 1'b0;
            if (WR) begin
                case (ADDR)
                    ADDR_IMR:   imr_q   <= wd[N_IRQ-1:0];
                    ADDR_VBASE: vbase_q <= wd[VEC_W-1:0] & ~IDX_MASK;
                    ADDR_MODE:  mode_q  <= wd[2:0];
                    default: ;
                endcase
            end
            case (state_q)
                IDLE: if (cand_ok) begin
                    state_q <= PEND;
                    int_q   <= 1'b1;
                end
                PEND: if (inta_fall) begin
                    state_q <= ACK1;
                    idx_q   <= cand_ok ? cand_idx : IDX_W'(N_IRQ - 1);
                    spur_q  <= !cand_ok;
                end
                ACK1: if (inta_fall) begin
                    vec_q       <= vbase_q | VEC_W'(idx_q);
                    vec_valid_q <= 1'b1;
                    int_q       <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        RDATA = '0;
        case (RD_SEL)
            RD_IRR:    RDATA = DW'(irr_q);
            RD_ISR:    RDATA = DW'(isr_q);
            RD_IMR:    RDATA = DW'(imr_q);
            RD_STATUS: RDATA = DW'({state_q, base_q});
            default:   RDATA = '0;
        endcase
    end

    assign INT       = int_q;
    assign VEC       = vec_q;
    assign VEC_VALID = vec_valid_q;

endmodule

// File: tb/tb_pic_core_n.sv
// Directed scoreboard bench for pic_core_n: an 8-line and a 16-line instance,
// expected vectors queued at the second INTA_ fall and checked on VEC_VALID.
module tb_pic_core_n;

    logic        clk = 1'b0;
    logic        rst_n, wr, inta_n, int_o, vec_valid;
    logic [7:0]  irq, wdata, rdata, vec;
    logic [1:0]  addr, rd_sel;

    logic        rst16_n, wr16, inta16_n, int16, vec_valid16;
    logic [15:0] irq16, wdata16, rdata16;
    logic [7:0]  vec16;
    logic [1:0]  addr16, rd_sel16;

    logic [7:0] exp_q[$];
    logic [7:0] exp16_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pic_core_n #(.N_IRQ(8), .VEC_W(8)) dut8 (
        .CLK(clk), .RST_(rst_n), .IRQ(irq), .WR(wr), .ADDR(addr), .WDATA(wdata),
        .RD_SEL(rd_sel), .RDATA(rdata), .INT(int_o), .INTA_(inta_n),
        .VEC(vec), .VEC_VALID(vec_valid)
    );

    pic_core_n #(.N_IRQ(16), .VEC_W(8)) dut16 (
        .CLK(clk), .RST_(rst16_n), .IRQ(irq16), .WR(wr16), .ADDR(addr16), .WDATA(wdata16),
        .RD_SEL(rd_sel16), .RDATA(rdata16), .INT(int16), .INTA_(inta16_n),
        .VEC(vec16), .VEC_VALID(vec_valid16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr8(input logic [1:0] a, input logic [7:0] d);
        wr = 1'b1; addr = a; wdata = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic wr16t(input logic [1:0] a, input logic [15:0] d);
        wr16 = 1'b1; addr16 = a; wdata16 = d;
        tick();
        wr16 = 1'b0;
    endtask

    task automatic rd8(input logic [1:0] sel, input logic [31:0] exp, input string name);
        rd_sel = sel;
        #1;
        chk(name, 32'(rdata), exp);
    endtask

    task automatic rd16(input logic [1:0] sel, input logic [31:0] exp, input string name);
        rd_sel16 = sel;
        #1;
        chk(name, 32'(rdata16), exp);
    endtask

    task automatic pulse8(input logic [7:0] lines);
        irq = lines;
        tick();
        irq = 8'h00;
        tick();
    endtask

    task automatic ack8(input logic [7:0] exp);
        inta_n = 1'b0; tick(); inta_n = 1'b1; tick();
        exp_q.push_back(exp);
        inta_n = 1'b0; tick(); inta_n = 1'b1; tick();
    endtask

    // Output monitors: every VEC_VALID strobe must match the oldest queued vector.
    always @(negedge clk) begin
        if (vec_valid) begin
            if (exp_q.size() == 0) chk("vec8_unexpected", 32'(vec), 32'hFFFF_FFFF);
            else chk("vec8", 32'(vec), 32'(exp_q.pop_front()));
        end
        if (vec_valid16) begin
            if (exp16_q.size() == 0) chk("vec16_unexpected", 32'(vec16), 32'hFFFF_FFFF);
            else chk("vec16", 32'(vec16), 32'(exp16_q.pop_front()));
        end
    end

    initial begin
        rst_n = 1'b0; wr = 1'b0; addr = 2'd0; wdata = 8'h00; rd_sel = 2'd0;
        irq = 8'h00; inta_n = 1'b1;
        rst16_n = 1'b0; wr16 = 1'b0; addr16 = 2'd0; wdata16 = 16'h0; rd_sel16 = 2'd0;
        irq16 = 16'h0; inta16_n = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1; rst16_n = 1'b1;
        tick();

        chk("rst_int", 32'(int_o), 0);
        chk("rst_vec", 32'(vec), 0);
        chk("rst_vec_valid", 32'(vec_valid), 0);
        rd8(2'd0, 32'h00, "rst_irr");
        rd8(2'd1, 32'h00, "rst_isr");
        rd8(2'd2, 32'hFF, "rst_imr");
        rd8(2'd3, 32'h00, "rst_status");

        // Single request on line 3; low base bits written as ones must be dropped.
        wr8(2'd0, 8'h00);
        wr8(2'd1, 8'h27);
        rd8(2'd2, 32'h00, "imr_write");
        irq = 8'h08;
        tick();
        chk("t1_int_not_yet", 32'(int_o), 0);
        rd8(2'd0, 32'h08, "t1_irr_set");
        irq = 8'h00;
        tick();
        chk("t1_int", 32'(int_o), 1);
        inta_n = 1'b0; tick(); inta_n = 1'b1; tick();
        rd8(2'd1, 32'h08, "t1_isr");
        rd8(2'd0, 32'h00, "t1_irr_cleared");
        exp_q.push_back(8'h23);
        inta_n = 1'b0; tick(); inta_n = 1'b1; tick();
        chk("t1_int_dropped", 32'(int_o), 0);
        wr8(2'd3, 8'h01);
        rd8(2'd1, 32'h00, "t1_nseoi");

        // Two simultaneous requests: lower index wins with base_ptr at 0.
        pulse8(8'h24);
        chk("t2_int", 32'(int_o), 1);
        ack8(8'h22);
        rd8(2'd1, 32'h04, "t2_isr");
        rd8(2'd0, 32'h20, "t2_irr");
        tick();
        chk("t2_blocked", 32'(int_o), 0);
        wr8(2'd3, 8'h01);
        tick();
        chk("t2_int_after_eoi", 32'(int_o), 1);
        ack8(8'h25);
        wr8(2'd3, 8'h01);
        rd8(2'd1, 32'h00, "t2_isr_clear");

        // Auto-EOI with rotation.
        wr8(2'd2, 8'h06);
        pulse8(8'h40);
        ack8(8'h26);
        rd8(2'd1, 32'h00, "t3_isr_aeoi");
        rd8(2'd3, 32'h07, "t3_base_ptr7");
        pulse8(8'h81);
        ack8(8'h27);
        ack8(8'h20);
        rd8(2'd3, 32'h01, "t3_base_ptr1");
        wr8(2'd2, 8'h00);

        // Nesting with base_ptr = 1 (priority 1,2,..,7,0).
        pulse8(8'h10);
        ack8(8'h24);
        rd8(2'd1, 32'h10, "t4_isr4");
        pulse8(8'h20);
        tick();
        chk("t4_lower_blocked", 32'(int_o), 0);
        rd8(2'd0, 32'h20, "t4_irr5_pending");
        pulse8(8'h02);
        chk("t4_nested_int", 32'(int_o), 1);
        ack8(8'h21);
        rd8(2'd1, 32'h12, "t4_isr_nested");
        wr8(2'd3, 8'h01);
        rd8(2'd1, 32'h10, "t4_nseoi_top");
        wr8(2'd3, 8'h92);
        rd8(2'd1, 32'h00, "t4_seoi4");
        rd8(2'd3, 32'h05, "t4_rot_base5");
        tick();
        chk("t4_int5", 32'(int_o), 1);
        ack8(8'h25);
        wr8(2'd3, 8'h01);
        wr8(2'd3, 8'h81);
        rd8(2'd3, 32'h05, "t4_eoi_empty_no_rot");
        rd8(2'd1, 32'h00, "t4_eoi_empty_isr");

        // Level mode: request withdrawn before the acknowledge.
        wr8(2'd2, 8'h01);
        irq = 8'h04;
        tick();
        tick();
        chk("t5_int", 32'(int_o), 1);
        rd8(2'd3, 32'h0D, "t5_status_pend");
        irq = 8'h00;
        tick();
        rd8(2'd0, 32'h00, "t5_irr_follows");
        chk("t5_int_held", 32'(int_o), 1);
        ack8(8'h27);
        rd8(2'd1, 32'h00, "t5_spurious_isr");
        chk("t5_int_low", 32'(int_o), 0);

        // Sixteen-line instance, then reset in the middle of a handshake.
        wr16t(2'd0, 16'h0000);
        wr16t(2'd1, 16'h0040);
        irq16 = 16'h8000; tick(); irq16 = 16'h0; tick();
        chk("n16_int", 32'(int16), 1);
        inta16_n = 1'b0; tick(); inta16_n = 1'b1; tick();
        exp16_q.push_back(8'h4F);
        inta16_n = 1'b0; tick(); inta16_n = 1'b1; tick();
        rd16(2'd1, 32'h8000, "n16_isr15");
        irq16 = 16'h0001; tick(); irq16 = 16'h0; tick();
        chk("n16_nested_int", 32'(int16), 1);
        inta16_n = 1'b0; tick(); inta16_n = 1'b1;
        rd16(2'd3, 32'h20, "n16_status_ack1");
        rst16_n = 1'b0;
        #1;
        chk("n16_rst_int", 32'(int16), 0);
        chk("n16_rst_vec", 32'(vec16), 0);
        rd16(2'd3, 32'h00, "n16_rst_status");
        rd16(2'd2, 32'hFFFF, "n16_rst_imr");
        rd16(2'd1, 32'h0000, "n16_rst_isr");
        tick();
        rst16_n = 1'b1;

        repeat (3) tick();
        chk("vec8_all_seen", 32'(exp_q.size()), 0);
        chk("vec16_all_seen", 32'(exp16_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
